// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack dealing controller: FSM states,
// result codes, rank limits and card valuation helpers.
package blackjack_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER,
        DEALER,
        RESOLVE,
        DONE
    } state_t;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_PUSH   = 2'b11;

    localparam logic [3:0] RANK_MIN  = 4'd1;
    localparam logic [3:0] RANK_MAX  = 4'd13;
    localparam logic [3:0] RANK_FACE = 4'd10;

    localparam logic [4:0] BJ_MAX    = 5'd21;
    localparam logic [4:0] ACE_BONUS = 5'd10;

    function automatic logic rankValid(input logic [3:0] rank);
        return (rank >= RANK_MIN) && (rank <= RANK_MAX);
    endfunction

    // Jack, queen and king all count as ten; the ace counts as one hard.
    function automatic logic [4:0] cardValue(input logic [3:0] rank);
        if (rank > RANK_FACE) begin
            return {1'b0, RANK_FACE};
        end
        return {1'b0, rank};
    endfunction

endpackage

// File: rtl/blackjack_hand_acc.sv
// One blackjack hand: a hard sum plus an ace flag, presenting the effective
// total (one ace promoted to eleven when that does not bust) and a bust flag.
module blackjack_hand_acc
    import blackjack_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic [3:0] rank_i,
    output logic [4:0] total_o,
    output logic       bust_o
);

    logic [4:0] r_hard;
    logic       r_ace;
    logic [4:0] w_soft;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_hard <= '0;
            r_ace  <= 1'b0;
        end else if (add_i) begin
            r_hard <= r_hard + cardValue(rank_i);
            if (rank_i == RANK_MIN) begin
                r_ace <= 1'b1;
            end
        end
    end

    // The hard sum never exceeds 31 because play stops once a hand busts.
    assign w_soft  = r_hard + ACE_BONUS;
    assign total_o = (r_ace && (r_hard <= (BJ_MAX - ACE_BONUS))) ? w_soft : r_hard;
    assign bust_o  = (total_o > BJ_MAX);

endmodule

// File: rtl/blackjack_deal_ctrl.sv
// Blackjack round controller: deals two cards each, runs the player's turn,
// then the dealer's draw-to-stand turn, and registers the round result.
module blackjack_deal_ctrl
    import blackjack_pkg::*;
#(
    parameter int unsigned DEALER_STAND = 17
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic       stand_i,
    output logic       card_req_o,
    input  logic [7:0] card_i,
    input  logic       card_valid_i,
    output logic [4:0] player_score_o,
    output logic [4:0] dealer_score_o,
    output logic [1:0] result_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [4:0] STAND_LVL = 5'(DEALER_STAND);

    state_t     r_state;
    logic       r_pending;
    logic       r_cardReq;
    logic [1:0] r_result;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_rank;
    logic       w_unusedHighBits;
    logic       w_accept;
    logic       w_discard;
    logic       w_clear;
    logic       w_addPlayer;
    logic       w_addDealer;
    logic [4:0] w_playerTotal;
    logic [4:0] w_dealerTotal;
    logic       w_playerBust;
    logic       w_dealerBust;

    assign w_rank           = card_i[3:0];
    assign w_unusedHighBits = ^card_i[7:4];

    // A card only counts while a request is outstanding; bad ranks are re-requested.
    assign w_accept  = card_valid_i && r_pending && rankValid(w_rank);
    assign w_discard = card_valid_i && r_pending && !rankValid(w_rank);
    assign w_clear   = start_i && ((r_state == IDLE) || (r_state == DONE));

    assign w_addPlayer = w_accept &&
                         ((r_state == DEAL_P1) || (r_state == DEAL_P2) || (r_state == PLAYER));
    assign w_addDealer = w_accept &&
                         ((r_state == DEAL_D1) || (r_state == DEAL_D2) || (r_state == DEALER));

    blackjack_hand_acc u_playerHand (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .add_i   (w_addPlayer),
        .rank_i  (w_rank),
        .total_o (w_playerTotal),
        .bust_o  (w_playerBust)
    );

    blackjack_hand_acc u_dealerHand (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .add_i   (w_addDealer),
        .rank_i  (w_rank),
        .total_o (w_dealerTotal),
        .bust_o  (w_dealerBust)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_cardReq <= 1'b0;
            r_result  <= RES_NONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cardReq <= w_discard;
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state   <= DEAL_P1;
                        r_cardReq <= 1'b1;
                        r_pending <= 1'b1;
                        r_result  <= RES_NONE;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                // Each deal step leaves the request outstanding for the next card.
                DEAL_P1: begin
                    if (w_accept) begin
                        r_state   <= DEAL_D1;
                        r_cardReq <= 1'b1;
                    end
                end
                DEAL_D1: begin
                    if (w_accept) begin
                        r_state   <= DEAL_P2;
                        r_cardReq <= 1'b1;
                    end
                end
                DEAL_P2: begin
                    if (w_accept) begin
                        r_state   <= DEAL_D2;
                        r_cardReq <= 1'b1;
                    end
                end
                DEAL_D2: begin
                    if (w_accept) begin
                        r_pending <= 1'b0;
                        r_state   <= (w_playerTotal == BJ_MAX) ? DEALER : PLAYER;
                    end
                end
                PLAYER: begin
                    if (r_pending) begin
                        if (w_accept) begin
                            r_pending <= 1'b0;
                        end
                    end else if (w_playerBust) begin
                        r_state <= RESOLVE;
                    end else if (stand_i) begin
                        r_state <= DEALER;
                    end else if (hit_i) begin
                        r_cardReq <= 1'b1;
                        r_pending <= 1'b1;
                    end
                end
                DEALER: begin
                    if (r_pending) begin
                        if (w_accept) begin
                            r_pending <= 1'b0;
                        end
                    end else if (w_dealerTotal < STAND_LVL) begin
                        r_cardReq <= 1'b1;
                        r_pending <= 1'b1;
                    end else begin
                        r_state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (w_playerBust) begin
                        r_result <= RES_DEALER;
                    end else if (w_dealerBust) begin
                        r_result <= RES_PLAYER;
                    end else if (w_playerTotal > w_dealerTotal) begin
                        r_result <= RES_PLAYER;
                    end else if (w_dealerTotal > w_playerTotal) begin
                        r_result <= RES_DEALER;
                    end else begin
                        r_result <= RES_PUSH;
                    end
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign card_req_o     = r_cardReq;
    assign player_score_o = w_playerTotal;
    assign dealer_score_o = w_dealerTotal;
    assign result_o       = r_result;
    assign busy_o         = r_busy;
    assign done_o         = r_done;

endmodule

// File: tb/tb_blackjack_deal_ctrl.sv
// Self-checking bench for blackjack_deal_ctrl: directed rounds plus random
// decks, each compared against a card-rules model of a whole round.
module tb_blackjack_deal_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       hit_i;
    logic       stand_i;
    logic       card_req_o;
    logic [7:0] card_i;
    logic       card_valid_i;
    logic [4:0] player_score_o;
    logic [4:0] dealer_score_o;
    logic [1:0] result_o;
    logic       busy_o;
    logic       done_o;

    int checks   = 0;
    int failures = 0;
    int deck[$];
    int srcPos;
    int reqCount;

    always #5 clk_i = ~clk_i;

    blackjack_deal_ctrl #(.DEALER_STAND(17)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .hit_i          (hit_i),
        .stand_i        (stand_i),
        .card_req_o     (card_req_o),
        .card_i         (card_i),
        .card_valid_i   (card_valid_i),
        .player_score_o (player_score_o),
        .dealer_score_o (dealer_score_o),
        .result_o       (result_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int cardVal(input int r);
        return (r > 10) ? 10 : r;
    endfunction

    function automatic int effTotal(input int hard, input bit ace);
        return (ace && (hard + 10 <= 21)) ? hard + 10 : hard;
    endfunction

    function automatic int nextValid(inout int pos);
        int r;
        r = 0;
        while (pos < deck.size()) begin
            r = deck[pos];
            pos++;
            if (r >= 1 && r <= 13) return r;
        end
        return 0;
    endfunction

    // Whole-round reference: mode 0 hits below thresh, 1 never acts, 2 holds both.
    task automatic modelRound(input int mode, input int thresh,
                              output int expP, output int expD, output int expRes, output int expUsed);
        int pos = 0;
        int pHard = 0;
        int dHard = 0;
        bit pAce = 0;
        bit dAce = 0;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = nextValid(pos);
            if (k % 2 == 0) begin pHard += cardVal(r); pAce |= (r == 1); end
            else            begin dHard += cardVal(r); dAce |= (r == 1); end
        end
        if (effTotal(pHard, pAce) != 21 && mode == 0) begin
            while (effTotal(pHard, pAce) < thresh) begin
                r = nextValid(pos);
                pHard += cardVal(r);
                pAce |= (r == 1);
            end
        end
        if (effTotal(pHard, pAce) > 21) begin
            expRes = 2;
        end else begin
            while (effTotal(dHard, dAce) < 17) begin
                r = nextValid(pos);
                dHard += cardVal(r);
                dAce |= (r == 1);
            end
            if (effTotal(dHard, dAce) > 21)                          expRes = 1;
            else if (effTotal(pHard, pAce) > effTotal(dHard, dAce))  expRes = 1;
            else if (effTotal(pHard, pAce) < effTotal(dHard, dAce))  expRes = 2;
            else                                                     expRes = 3;
        end
        expP    = effTotal(pHard, pAce);
        expD    = effTotal(dHard, dAce);
        expUsed = pos;
    endtask

    // Starts a round and plays both the card source and the player until done_o
    // (or until the stopAtReq-th card request, which is left unanswered).
    task automatic applyStimulus(input int mode, input int thresh, input int stopAtReq, output bit timedOut);
        int waitCnt = -1;
        reqCount = 0;
        srcPos   = 0;
        timedOut = 1'b1;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("busyAfterStart", busy_o, 1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            card_valid_i = 1'b0;
            if (card_req_o) begin
                reqCount++;
                if (stopAtReq != 0 && reqCount == stopAtReq) begin
                    timedOut = 1'b0;
                    break;
                end
                waitCnt = $urandom_range(0, 2);
            end
            if (waitCnt == 0) begin
                card_valid_i = 1'b1;
                card_i = {4'($urandom_range(0, 15)), (srcPos < deck.size()) ? 4'(deck[srcPos]) : 4'd0};
                srcPos++;
                waitCnt = -1;
            end else if (waitCnt > 0) begin
                waitCnt--;
            end
            case (mode)
                0: begin hit_i = (int'(player_score_o) < thresh); stand_i = !hit_i; end
                1: begin hit_i = 1'b0; stand_i = 1'b0; end
                default: begin hit_i = 1'b1; stand_i = 1'b1; end
            endcase
            if (done_o) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk_i);
        end
        card_valid_i = 1'b0;
        hit_i        = 1'b0;
        stand_i      = 1'b0;
    endtask

    task automatic runRound(input string name, input int mode, input int thresh);
        int eP, eD, eR, eU;
        bit to;
        modelRound(mode, thresh, eP, eD, eR, eU);
        applyStimulus(mode, thresh, 0, to);
        checkOutput({name, ".timeout"}, to, 0);
        checkOutput({name, ".player"}, player_score_o, eP);
        checkOutput({name, ".dealer"}, dealer_score_o, eD);
        checkOutput({name, ".result"}, result_o, eR);
        checkOutput({name, ".busy"}, busy_o, 0);
        checkOutput({name, ".reqs"}, reqCount, eU);
        checkOutput({name, ".cardsUsed"}, srcPos, eU);
        repeat (2) @(negedge clk_i);
        checkOutput({name, ".doneHold"}, done_o, 1);
        checkOutput({name, ".resultHold"}, result_o, eR);
    endtask

    initial begin
        bit to;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        hit_i        = 1'b0;
        stand_i      = 1'b0;
        card_i       = 8'h00;
        card_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset.req", card_req_o, 0);
        checkOutput("reset.player", player_score_o, 0);
        checkOutput("reset.dealer", dealer_score_o, 0);
        checkOutput("reset.result", result_o, 0);
        checkOutput("reset.busy", busy_o, 0);
        checkOutput("reset.done", done_o, 0);

        deck = '{10, 9, 7, 8};
        runRound("push17", 0, 17);

        deck = '{1, 6, 13, 5, 2, 4};
        runRound("natural21", 1, 0);

        deck = '{10, 10, 6, 7, 9, 5};
        runRound("playerBust", 0, 17);

        deck = '{0, 14, 5, 9, 6, 8};
        runRound("badRanks", 0, 11);

        deck = '{10, 10, 5, 8, 3};
        runRound("hitAndStand", 2, 0);

        deck = '{10, 2, 6, 3, 5};
        applyStimulus(0, 0, 5, to);
        checkOutput("midReset.reachedDealerReq", to, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        card_valid_i = 1'b1;
        card_i = 8'h05;
        @(negedge clk_i);
        checkOutput("midReset.reqDuringValid", card_req_o, 0);
        card_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("midReset.req", card_req_o, 0);
        checkOutput("midReset.player", player_score_o, 0);
        checkOutput("midReset.dealer", dealer_score_o, 0);
        checkOutput("midReset.result", result_o, 0);
        checkOutput("midReset.busy", busy_o, 0);
        checkOutput("midReset.done", done_o, 0);

        for (int n = 0; n < 40; n++) begin
            deck.delete();
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 15) == 0) deck.push_back($urandom_range(0, 15));
                else                            deck.push_back($urandom_range(1, 13));
            end
            runRound($sformatf("rand%0d", n), 0, $urandom_range(12, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
